// File: rtl/sdith_pkg.sv
// rtl/sdith_pkg.sv - shared state encoding and sizing helpers for the signing datapath
package sdith_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_SQUEEZE,
      ST_EXTRACT,
      ST_FLUSH,
      ST_DONE
   } evc_state_t;

   // ceil(log2(x)) with a one-bit floor so tiny memories still get an address bit
   function automatic int clog2_c(input int x);
      return (x <= 2) ? 1 : $clog2(x);
   endfunction

   // security level name to LAMBDA; unknown names fall back to the L1 size
   function automatic int lambda_of(input logic [15:0] ps);
      case (ps)
         "L3":    return 192;
         "L5":    return 256;
         default: return 128;
      endcase
   endfunction

endpackage

// File: rtl/byte_rejection_sampler.sv
// rtl/byte_rejection_sampler.sv - candidate acceptance logic and used-index bitmap
module byte_rejection_sampler #(
   parameter int N_PARTIES = 256,
   parameter bit DISTINCT  = 1'b0
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] c,
   input  logic       clear,
   input  logic       set,
   output logic       accept
);

   logic [N_PARTIES-1:0] used;
   logic                 in_range;
   logic                 seen;

   // out-of-range candidates never match a bitmap position, so they read as unseen
   always_comb begin
      in_range = int'(c) < N_PARTIES;
      seen     = 1'b0;
      for (int i = 0; i < N_PARTIES; i++)
         if (int'(c) == i) seen = used[i];
      accept = in_range && (!DISTINCT || !seen);
   end

   // clear wins over set so a new run never inherits marks from the previous one
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         used <= '0;
      end else if (set && accept) begin
         for (int i = 0; i < N_PARTIES; i++)
            if (int'(c) == i) used[i] <= 1'b1;
      end
   end

endmodule

// File: rtl/expand_view_challenge_rs.sv
// rtl/expand_view_challenge_rs.sv - squeezes the XOF stream into TAU hidden-party indices
module expand_view_challenge_rs
   import sdith_pkg::*;
#(
   parameter logic [15:0] PARAMETER_SET = "L1",
   parameter int          TAU           = 17,
   parameter int          D_HYPERCUBE   = 8,
   parameter int          N_PARTIES     = 2**D_HYPERCUBE,
   parameter int          DISTINCT      = 0,
   parameter int          MAX_SQ_WORDS  = 32,
   localparam int         LAMBDA        = lambda_of(PARAMETER_SET),
   localparam int         H2_WORDS      = 2 * LAMBDA / 32,
   localparam int         H2_AW         = clog2_c(H2_WORDS),
   localparam int         TAU_AW        = clog2_c(TAU)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_done,
   output logic              o_fail,
   input  logic              i_h2_wr_en,
   input  logic              i_h2_rd_en,
   input  logic [H2_AW-1:0]  i_h2_addr,
   input  logic [31:0]       i_h2,
   output logic [31:0]       o_h2,
   input  logic [TAU_AW-1:0] i_i_star_addr,
   input  logic              i_i_star_rd_en,
   output logic [7:0]        o_i_star,
   output logic [31:0]       o_hash_data_in,
   input  logic [H2_AW-1:0]  i_hash_addr,
   input  logic              i_hash_rd_en,
   input  logic [31:0]       i_hash_data_out,
   input  logic              i_hash_data_out_valid,
   output logic              o_hash_data_out_ready,
   output logic [31:0]       o_hash_input_length,
   output logic [31:0]       o_hash_output_length,
   output logic              o_hash_start,
   output logic              o_hash_force_done,
   input  logic              i_hash_force_done_ack
);

   localparam int         K_W    = clog2_c(TAU + 1);
   localparam int         W_W    = clog2_c(MAX_SQ_WORDS + 1);
   localparam logic [7:0] C_MASK = 8'((1 << D_HYPERCUBE) - 1);

   evc_state_t     state;
   logic [K_W-1:0] k;
   logic [W_W-1:0] w;
   logic [1:0]     byte_sel;
   logic [31:0]    word;
   logic           budget_out;
   logic [7:0]     cand;
   logic           accept;
   logic           clear_used;
   logic           set_used;
   logic           istar_we;
   logic           last_accept;

   logic [31:0]    h2_mem     [H2_WORDS];
   logic [7:0]     i_star_mem [TAU];

   assign o_hash_input_length  = 32'(2 * LAMBDA);
   assign o_hash_output_length = 32'(32 * MAX_SQ_WORDS);

   assign cand        = word[{byte_sel, 3'b000} +: 8] & C_MASK;
   assign clear_used  = (state == ST_IDLE) && i_start;
   assign set_used    = (state == ST_EXTRACT);
   assign istar_we    = set_used && accept;
   assign last_accept = (k == K_W'(TAU - 1));

   byte_rejection_sampler #(
      .N_PARTIES (N_PARTIES),
      .DISTINCT  (DISTINCT != 0)
   ) u_sampler (
      .clk    (i_clk),
      .resetn (i_rst),
      .c      (cand),
      .clear  (clear_used),
      .set    (set_used),
      .accept (accept)
   );

   // control FSM; strobes are registers set on the transition that needs them
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state                 <= ST_IDLE;
         k                     <= '0;
         w                     <= '0;
         byte_sel              <= '0;
         word                  <= '0;
         budget_out            <= 1'b0;
         o_done                <= 1'b0;
         o_fail                <= 1'b0;
         o_hash_start          <= 1'b0;
         o_hash_force_done     <= 1'b0;
         o_hash_data_out_ready <= 1'b0;
      end else begin
         o_done       <= 1'b0;
         o_hash_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  k            <= '0;
                  w            <= '0;
                  budget_out   <= 1'b0;
                  o_fail       <= 1'b0;
                  o_hash_start <= 1'b1;
                  state        <= ST_START;
               end
            end
            ST_START: begin
               o_hash_data_out_ready <= 1'b1;
               state                 <= ST_SQUEEZE;
            end
            ST_SQUEEZE: begin
               if (i_hash_data_out_valid && o_hash_data_out_ready) begin
                  word                  <= i_hash_data_out;
                  w                     <= w + 1'b1;
                  byte_sel              <= 2'd0;
                  o_hash_data_out_ready <= 1'b0;
                  state                 <= ST_EXTRACT;
               end
            end
            ST_EXTRACT: begin
               byte_sel <= byte_sel + 2'd1;
               if (accept) k <= k + 1'b1;
               // filling the last slot ends the run even mid-word and even on the final budgeted word
               if (accept && last_accept) begin
                  o_hash_force_done <= 1'b1;
                  state             <= ST_FLUSH;
               end else if (byte_sel == 2'd3) begin
                  if (w == W_W'(MAX_SQ_WORDS)) begin
                     budget_out        <= 1'b1;
                     o_hash_force_done <= 1'b1;
                     state             <= ST_FLUSH;
                  end else begin
                     o_hash_data_out_ready <= 1'b1;
                     state                 <= ST_SQUEEZE;
                  end
               end
            end
            ST_FLUSH: begin
               if (i_hash_force_done_ack) begin
                  o_hash_force_done <= 1'b0;
                  o_fail            <= budget_out;
                  o_done            <= 1'b1;
                  state             <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // RAM writes; host h2 writes are only taken while the hash cannot be reading
   always_ff @(posedge i_clk) begin
      if (i_rst && i_h2_wr_en && (state == ST_IDLE) && (int'(i_h2_addr) < H2_WORDS))
         h2_mem[i_h2_addr] <= i_h2;
      if (i_rst && istar_we)
         i_star_mem[k[TAU_AW-1:0]] <= cand;
   end

   // registered read ports; a read colliding with a write returns the pre-write word
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_h2           <= '0;
         o_hash_data_in <= '0;
         o_i_star       <= '0;
      end else begin
         if (i_h2_rd_en && (state == ST_IDLE))
            o_h2 <= (int'(i_h2_addr) < H2_WORDS) ? h2_mem[i_h2_addr] : '0;
         if (i_hash_rd_en)
            o_hash_data_in <= (int'(i_hash_addr) < H2_WORDS) ? h2_mem[i_hash_addr] : '0;
         if (i_i_star_rd_en)
            o_i_star <= (int'(i_i_star_addr) < TAU) ? i_star_mem[i_i_star_addr] : '0;
      end
   end

endmodule

// File: tb/tb_expand_view_challenge_rs.sv
// tb/tb_expand_view_challenge_rs.sv - directed vector bench for the view-challenge expander
`timescale 1ns/1ps
module tb_expand_view_challenge_rs;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [2:0]       start_s, sr_en, valid_s, ack_s;
   logic [2:0][31:0] hdata_s;
   logic             h2_wr_en, h2_rd_en, hash_rd_en;
   logic [2:0]       h2_addr, hash_addr;
   logic [31:0]      h2_wdata;
   logic [4:0]       sa;
   wire  [2:0]       done_w, fail_w, rdy_w, hstart_w, fdone_w;
   wire  [2:0][7:0]  istar_w;
   wire  [2:0][31:0] h2_w, hdin_w, inlen_w, outlen_w;

   // unit 0: defaults; unit 1: N=200 distinct, 3-word budget; unit 2: D=4
   expand_view_challenge_rs u_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_s[0]), .o_done(done_w[0]), .o_fail(fail_w[0]),
      .i_h2_wr_en(h2_wr_en), .i_h2_rd_en(h2_rd_en), .i_h2_addr(h2_addr), .i_h2(h2_wdata), .o_h2(h2_w[0]),
      .i_i_star_addr(sa), .i_i_star_rd_en(sr_en[0]), .o_i_star(istar_w[0]),
      .o_hash_data_in(hdin_w[0]), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd_en),
      .i_hash_data_out(hdata_s[0]), .i_hash_data_out_valid(valid_s[0]), .o_hash_data_out_ready(rdy_w[0]),
      .o_hash_input_length(inlen_w[0]), .o_hash_output_length(outlen_w[0]),
      .o_hash_start(hstart_w[0]), .o_hash_force_done(fdone_w[0]), .i_hash_force_done_ack(ack_s[0]));

   expand_view_challenge_rs #(.TAU(4), .N_PARTIES(200), .DISTINCT(1), .MAX_SQ_WORDS(3)) u_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_s[1]), .o_done(done_w[1]), .o_fail(fail_w[1]),
      .i_h2_wr_en(h2_wr_en), .i_h2_rd_en(h2_rd_en), .i_h2_addr(h2_addr), .i_h2(h2_wdata), .o_h2(h2_w[1]),
      .i_i_star_addr(sa[1:0]), .i_i_star_rd_en(sr_en[1]), .o_i_star(istar_w[1]),
      .o_hash_data_in(hdin_w[1]), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd_en),
      .i_hash_data_out(hdata_s[1]), .i_hash_data_out_valid(valid_s[1]), .o_hash_data_out_ready(rdy_w[1]),
      .o_hash_input_length(inlen_w[1]), .o_hash_output_length(outlen_w[1]),
      .o_hash_start(hstart_w[1]), .o_hash_force_done(fdone_w[1]), .i_hash_force_done_ack(ack_s[1]));

   expand_view_challenge_rs #(.TAU(4), .D_HYPERCUBE(4)) u_c (
      .i_clk(clk), .i_rst(rst), .i_start(start_s[2]), .o_done(done_w[2]), .o_fail(fail_w[2]),
      .i_h2_wr_en(h2_wr_en), .i_h2_rd_en(h2_rd_en), .i_h2_addr(h2_addr), .i_h2(h2_wdata), .o_h2(h2_w[2]),
      .i_i_star_addr(sa[1:0]), .i_i_star_rd_en(sr_en[2]), .o_i_star(istar_w[2]),
      .o_hash_data_in(hdin_w[2]), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd_en),
      .i_hash_data_out(hdata_s[2]), .i_hash_data_out_valid(valid_s[2]), .o_hash_data_out_ready(rdy_w[2]),
      .o_hash_input_length(inlen_w[2]), .o_hash_output_length(outlen_w[2]),
      .o_hash_start(hstart_w[2]), .o_hash_force_done(fdone_w[2]), .i_hash_force_done_ack(ack_s[2]));

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] u;
      logic [4:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   rd_vec_t     tbl [14];
   logic [31:0] stim [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic rd_istar(input int u, input logic [4:0] a, output logic [7:0] v);
      @(negedge clk); sa = a; sr_en[u] = 1'b1;
      @(negedge clk); sr_en[u] = 1'b0; v = istar_w[u];
   endtask

   // drives one run from stim[], acting as hash stub and force-done acknowledger
   task automatic run(input int u, input string tag, input int exp_cyc, input int exp_words,
                      input logic exp_fail, input bit exp_fd);
      int   wi = 0;
      bit   adv = 0;
      bit   got = 0;
      bit   saw_fd = 0;
      int   cyc = 0;
      logic fl = 1'b0;
      @(negedge clk);
      start_s[u] = 1'b1;
      hdata_s[u] = stim[0];
      valid_s[u] = 1'b1;
      @(negedge clk);
      start_s[u] = 1'b0;
      check({tag, "_hash_start"}, 32'(hstart_w[u]), 32'd1);
      check({tag, "_fail_cleared"}, 32'(fail_w[u]), 32'd0);
      for (int cy = 1; cy <= 400; cy++) begin
         @(negedge clk);
         if (done_w[u]) begin got = 1; cyc = cy; fl = fail_w[u]; break; end
         if (fdone_w[u]) saw_fd = 1;
         ack_s[u] = fdone_w[u];
         if (adv) begin
            wi++; adv = 0;
            if (wi < stim.size()) hdata_s[u] = stim[wi]; else valid_s[u] = 1'b0;
         end
         if (valid_s[u] && rdy_w[u]) adv = 1;
      end
      valid_s[u] = 1'b0;
      ack_s[u]   = 1'b0;
      check({tag, "_done"}, 32'(got), 32'd1);
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_words"}, 32'(wi), 32'(exp_words));
      check({tag, "_fail"}, 32'(fl), 32'(exp_fail));
      if (exp_fd) check({tag, "_force_done_seen"}, 32'(saw_fd), 32'd1);
   endtask

   initial begin
      logic [7:0] v;
      int         bad;
      rst = 1'b0; start_s = '0; sr_en = '0; valid_s = '0; ack_s = '0; hdata_s = '0;
      h2_wr_en = 1'b0; h2_rd_en = 1'b0; hash_rd_en = 1'b0;
      h2_addr = '0; hash_addr = '0; h2_wdata = '0; sa = '0;

      tbl[0]  = '{2'd0, 5'd0,  8'd0};
      tbl[1]  = '{2'd0, 5'd1,  8'd1};
      tbl[2]  = '{2'd0, 5'd3,  8'd3};
      tbl[3]  = '{2'd0, 5'd8,  8'd8};
      tbl[4]  = '{2'd0, 5'd15, 8'd15};
      tbl[5]  = '{2'd0, 5'd16, 8'd16};
      tbl[6]  = '{2'd1, 5'd0,  8'd1};
      tbl[7]  = '{2'd1, 5'd1,  8'd7};
      tbl[8]  = '{2'd1, 5'd2,  8'd5};
      tbl[9]  = '{2'd1, 5'd3,  8'd2};
      tbl[10] = '{2'd2, 5'd0,  8'd7};
      tbl[11] = '{2'd2, 5'd1,  8'd10};
      tbl[12] = '{2'd2, 5'd2,  8'd11};
      tbl[13] = '{2'd2, 5'd3,  8'd12};

      repeat (3) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         check($sformatf("reset_ctl_u%0d", u),
               {27'd0, done_w[u], fail_w[u], rdy_w[u], hstart_w[u], fdone_w[u]}, 32'd0);
         check($sformatf("reset_rd_u%0d", u), {24'd0, istar_w[u]} | h2_w[u] | hdin_w[u], 32'd0);
      end
      rst = 1'b1;
      check("in_len_l1", inlen_w[0], 32'd256);
      check("out_len_a", outlen_w[0], 32'd1024);
      check("out_len_b", outlen_w[1], 32'd96);

      @(negedge clk); h2_addr = 3'd2; h2_wdata = 32'hDEAD_BEEF; h2_wr_en = 1'b1;
      @(negedge clk); h2_addr = 3'd5; h2_wdata = 32'h1234_5678;
      @(negedge clk); h2_wr_en = 1'b0; h2_addr = 3'd2; h2_rd_en = 1'b1; hash_addr = 3'd5; hash_rd_en = 1'b1;
      @(negedge clk); h2_rd_en = 1'b0; hash_rd_en = 1'b0;
      check("h2_host_read", h2_w[0], 32'hDEAD_BEEF);
      check("h2_hash_read", hdin_w[0], 32'h1234_5678);

      stim.delete();
      for (int j = 0; j < 5; j++)
         stim.push_back({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
      run(0, "a_seq", 24, 5, 1'b0, 1'b1);

      stim = '{32'hC8FF_0701, 32'h0505_0505, 32'h0302_0105};
      run(1, "b_distinct", 16, 3, 1'b0, 1'b1);

      stim = '{32'h3C2B_1AA7};
      run(2, "c_mask", 7, 1, 1'b0, 1'b1);

      for (int i = 0; i < 14; i++) begin
         rd_istar(int'(tbl[i].u), tbl[i].addr, v);
         check($sformatf("istar_vec%0d_u%0d_a%0d", i, tbl[i].u, tbl[i].addr), 32'(v), 32'(tbl[i].exp));
      end

      stim = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      run(1, "b_exhaust", 17, 3, 1'b1, 1'b1);
      rd_istar(1, 5'd1, v);
      check("b_stale_after_fail", 32'(v), 32'd7);

      stim = '{32'hC8FF_0701, 32'h0505_0505, 32'h0302_0105};
      run(1, "b_rerun", 16, 3, 1'b0, 1'b0);

      @(negedge clk); start_s[0] = 1'b1; hdata_s[0] = 32'h0302_0100; valid_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      @(negedge clk);
      @(negedge clk); valid_s[0] = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      check("midrun_reset_ctl", {27'd0, done_w[0], fail_w[0], rdy_w[0], hstart_w[0], fdone_w[0]}, 32'd0);
      check("midrun_reset_rd", {24'd0, istar_w[0]} | h2_w[0] | hdin_w[0], 32'd0);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_w[0] || hstart_w[0] || fdone_w[0] || rdy_w[0]) bad++;
      end
      check("midrun_reset_quiet", 32'(bad), 32'd0);

      stim.delete();
      for (int j = 0; j < 5; j++)
         stim.push_back({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
      run(0, "a_after_reset", 24, 5, 1'b0, 1'b1);
      rd_istar(0, 5'd4, v);
      check("a_after_reset_istar4", 32'(v), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
